nbit_seq_divider: RTL and testbench
===================================

# nbit_seq_divider

Sequential n-bit restoring divider that produces quotient and remainder from a dividend and divisor. It resolves one quotient bit per clock through a trial subtraction on the team's `nbit_add_sub`. It sits beside the combinational adder/subtractor as the iterative inverse-arithmetic unit in the datapath. Each operation uses a start/done handshake.

## Interface
- `n`, default 4: operand, quotient and remainder width in bits (≥2).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to divide. Sampled only in IDLE.
- `x` input n: dividend. Sampled on the edge that accepts `start`.
- `y` input n: divisor. Sampled on the edge that accepts `start`.
- `busy` output 1: high while iterating.
- `done` output 1: one-cycle pulse. Results are valid from this cycle onward.
- `q` output n: quotient. Held until the next accepted `start`.
- `r` output n: remainder. Held until the next accepted `start`.
- `div_by_zero` output 1: `y` was 0. Held with the results.
- `overflow` output 1: signed overflow. Held with the results.

## Operation
- FSM states:
  - IDLE: waits for `start`. `start`=1 latches `x` and `y`, then:
    - `y`=0: go to DONE.
    - otherwise: load the partial remainder (n+1 bits) with 0, load the dividend shift register with `x`, set the step counter to n−1, go to RUN.
  - RUN: one step per cycle.
    - Shift {partial remainder, dividend} left by 1.
    - Trial = partial remainder − divisor (n+1 bits).
    - Carry-out 1 (no borrow): keep the trial and shift in quotient bit 1.
    - Carry-out 0: restore the partial remainder and shift in quotient bit 0.
    - Counter = 0: go to DONE. Otherwise decrement the counter.
  - DONE: drive `done`=1 and update `q`, `r` and the flags. Return to IDLE the next edge.
- Divide by zero: `div_by_zero`=1, `q`=all ones, `r`=`x`, `overflow`=0.
- `start` in RUN or DONE is ignored. It is neither queued nor able to corrupt the operation.
- Changing `x` or `y` after acceptance has no effect.
- `q`, `r` and the flags are written only on entry to DONE. They are stable between operations.
- Width rule: the trial subtraction is n+1 bits wide, so a divisor with its MSB set never falsely compares.

## Timing
- Reset (async assert, any state): state=IDLE; `busy`=0, `done`=0, `q`=0, `r`=0, `div_by_zero`=0, `overflow`=0. An operation in progress is abandoned. No `done` is produced for it.
- Reset deassertion is synchronised externally. The first `start` can be accepted on the first edge after deassertion.
- Let E0 be the edge that accepts `start`.
  - `busy` is high after E0 through edge En (n cycles).
  - `done` is high for exactly the one cycle after En. `busy`=0 during that cycle.
- Divide by zero: `done` is high for the cycle after E0. `busy` stays 0.
- Throughput: a new `start` is accepted at the earliest on the edge after the `done` cycle. Minimum interval is n+2 cycles.
- `done` and `busy` are never high together.

## Configuration
- `NBIT_DIV_SIGNED_EN` defined: operands are two's complement.
  - At E0 the magnitudes of `x` and `y` are taken and their signs recorded.
  - At DONE, `q` is negated if the signs differ, and `r` takes the sign of `x` (truncating division).
  - `x` = −2^(n−1) with `y` = −1 gives `overflow`=1 and `q`=−2^(n−1) (wrapped), `r`=0.
  - Divide by zero still returns `q`=all ones, `r`=`x`.
- `NBIT_DIV_SIGNED_EN` undefined: operation is unsigned and `overflow` is tied 0. Latency is identical in both builds.

## Structure
- Package `nbit_div_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the divide-by-zero quotient constant (all ones) as a function of width.
- Sub-module: one `nbit_add_sub` instance with `n`=n+1 and `control_bit` tied to 1. It performs the trial subtraction, and its `cout` is the no-borrow/quotient bit. Its `overflow` output is unused.
- The counter is $clog2(n) bits wide.

## Test plan
- n=4, unsigned, `x`=13, `y`=3, one-cycle `start` → `busy` for 4 cycles, then `done` pulse with `q`=4, `r`=1, flags 0.
- `x`=7, `y`=0 → `done` in the cycle after E0, `busy` never high, `div_by_zero`=1, `q`=15, `r`=7.
- `x`=15, `y`=1 and `x`=2, `y`=9 → `q`=15, `r`=0, then `q`=0, `r`=2. Back-to-back `start` held high gives results n+2 cycles apart.
- `start` held high and `x`/`y` changed during RUN → original result, exactly one `done` per accept.
- `rst_n` pulsed low at RUN cycle 2 → all outputs 0 immediately, no `done`. A later `x`=9, `y`=4 gives `q`=2, `r`=1.
- With `NBIT_DIV_SIGNED_EN`:
  - `x`=−7 (4'b1001), `y`=2 → `q`=4'b1101 (−3), `r`=4'b1111 (−1).
  - `x`=−8, `y`=−1 → `overflow`=1, `q`=4'b1000, `r`=0.

Source files
------------

// File: rtl/nbit_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package nbit_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Quotient reported on divide-by-zero: all ones at the given width (width <= 32).
    function automatic logic [31:0] dbz_quotient(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/nbit_add_sub.sv
// Combinational n-bit adder/subtractor: s = a + b (control_bit=0) or a - b (control_bit=1).
module nbit_add_sub #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         control_bit,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         overflow
);

    logic [n-1:0] b_eff;
    logic [n:0]   sum;

    assign b_eff = b ^ {n{control_bit}};
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, control_bit};

    assign s        = sum[n-1:0];
    assign cout     = sum[n];
    assign overflow = (a[n-1] == b_eff[n-1]) && (s[n-1] != a[n-1]);

endmodule

// File: rtl/nbit_seq_divider.sv
// Sequential restoring divider, one quotient bit per clock via a trial subtraction.
// Define NBIT_DIV_SIGNED_EN for two's-complement (truncating) division.
module nbit_seq_divider
    import nbit_div_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] q,
    output logic [n-1:0] r,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(n);
    localparam logic [n-1:0] DBZ_Q = n'(dbz_quotient(n));

    state_e       state_q, state_d;
    logic [n:0]   rem_q, rem_d;
    logic [n-1:0] dvd_q, dvd_d;
    logic [n-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0] res_q_q, res_q_d;
    logic [n-1:0] res_r_q, res_r_d;
    logic         dbz_q, dbz_d;

    logic [n-1:0] x_mag, y_mag;
    logic [n:0]   shifted, trial;
    logic         no_borrow;
    logic         add_ovf_unused;
    logic         unused_rem_msb;
    logic [n-1:0] qmag, rmag;

`ifdef NBIT_DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;

    assign x_mag = x[n-1] ? (~x + 1'b1) : x;
    assign y_mag = y[n-1] ? (~y + 1'b1) : y;
`else
    assign x_mag = x;
    assign y_mag = y;
`endif

    // The stored remainder is always below the divisor, so its MSB never feeds the next shift.
    assign shifted        = {rem_q[n-1:0], dvd_q[n-1]};
    assign unused_rem_msb = rem_q[n];

    nbit_add_sub #(
        .n(n + 1)
    ) u_trial_sub (
        .a          (shifted),
        .b          ({1'b0, dvs_q}),
        .control_bit(1'b1),
        .s          (trial),
        .cout       (no_borrow),
        .overflow   (add_ovf_unused)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;
        dbz_d   = dbz_q;
        qmag    = '0;
        rmag    = '0;
`ifdef NBIT_DIV_SIGNED_EN
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (y == '0) begin
                        state_d = DONE;
                        res_q_d = DBZ_Q;
                        res_r_d = x;
                        dbz_d   = 1'b1;
`ifdef NBIT_DIV_SIGNED_EN
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = RUN;
                        rem_d   = '0;
                        dvd_d   = x_mag;
                        dvs_d   = y_mag;
                        cnt_d   = CW'(n - 1);
`ifdef NBIT_DIV_SIGNED_EN
                        neg_q_d    = x[n-1] ^ y[n-1];
                        neg_r_d    = x[n-1];
                        ovf_pend_d = (x == {1'b1, {(n-1){1'b0}}}) && (y == '1);
`endif
                    end
                end
            end

            RUN: begin
                rem_d = no_borrow ? trial : shifted;
                dvd_d = {dvd_q[n-2:0], no_borrow};
                if (cnt_q == '0) begin
                    // Results are registered on the edge entering DONE, from this step's values.
                    state_d = DONE;
                    qmag    = dvd_d;
                    rmag    = rem_d[n-1:0];
                    dbz_d   = 1'b0;
`ifdef NBIT_DIV_SIGNED_EN
                    res_q_d = neg_q_q ? (~qmag + 1'b1) : qmag;
                    res_r_d = neg_r_q ? (~rmag + 1'b1) : rmag;
                    ovf_d   = ovf_pend_q;
`else
                    res_q_d = qmag;
                    res_r_d = rmag;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            res_q_q <= '0;
            res_r_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef NBIT_DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign q           = res_q_q;
    assign r           = res_r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nbit_seq_divider.sv
// Self-checking bench for nbit_seq_divider against an arithmetic reference model.
module tb_nbit_seq_divider;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;
    logic         overflow;

    int tests;
    int failures;

    nbit_seq_divider #(
        .n(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .r          (r),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division on the operand values.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] eq, output logic [N-1:0] er,
                                  output logic edbz, output logic eovf);
        int sa;
        int sb;
        eovf = 1'b0;
        edbz = 1'b0;
        if (b == 0) begin
            eq   = '1;
            er   = a;
            edbz = 1'b1;
            return;
        end
`ifdef NBIT_DIV_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
        if (sa == -(2 ** (N - 1)) && sb == -1) begin
            eq   = a;
            er   = '0;
            eovf = 1'b1;
        end else begin
            eq = N'(sa / sb);
            er = N'(sa % sb);
        end
`else
        sa = int'(a);
        sb = int'(b);
        eq = N'(sa / sb);
        er = N'(sa % sb);
`endif
    endfunction

    // Drives one accepted operation and observes it; leaves the DUT back in IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int busy_cyc, output int lat,
                          output logic [N-1:0] oq, output logic [N-1:0] orr,
                          output logic odbz, output logic oovf, output bit clash);
        busy_cyc = 0;
        lat      = -1;
        clash    = 1'b0;
        oq       = '0;
        orr      = '0;
        odbz     = 1'b0;
        oovf     = 1'b0;
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk); #1;
        start = 1'b0;
        x     = N'($urandom);
        y     = N'($urandom);
        for (int k = 1; k <= 3 * N + 6; k++) begin
            if (busy && done) clash = 1'b1;
            if (busy) busy_cyc++;
            if (done) begin
                lat  = k;
                oq   = q;
                orr  = r;
                odbz = div_by_zero;
                oovf = overflow;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        @(posedge clk); #2;
        tests++;
        if ({busy, done, q, r, div_by_zero, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b ovf=%b, need all 0",
                     busy, done, q, r, div_by_zero, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        int busy_cyc, lat;
        logic [N-1:0] oq, orr, eq, er;
        logic odbz, oovf, edbz, eovf;
        bit clash;
        int elat, ebusy;
        model(a, b, eq, er, edbz, eovf);
        elat  = edbz ? 1 : N + 1;
        ebusy = edbz ? 0 : N;
        run_op(a, b, busy_cyc, lat, oq, orr, odbz, oovf, clash);
        tests++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s latency: x=%0d y=%0d got %0d need %0d", name, a, b, lat, elat);
        end
        tests++;
        if (busy_cyc !== ebusy || clash) begin
            failures++;
            $display("FAIL %s busy: x=%0d y=%0d got %0d cycles clash=%0b need %0d no clash",
                     name, a, b, busy_cyc, clash, ebusy);
        end
        tests++;
        if ({oq, orr, odbz, oovf} !== {eq, er, edbz, eovf}) begin
            failures++;
            $display("FAIL %s result: x=%0d y=%0d got q=%0d r=%0d dbz=%b ovf=%b need q=%0d r=%0d dbz=%b ovf=%b",
                     name, a, b, oq, orr, odbz, oovf, eq, er, edbz, eovf);
        end
        tests++;
        if ({q, r, div_by_zero, overflow} !== {eq, er, edbz, eovf}) begin
            failures++;
            $display("FAIL %s held: got q=%0d r=%0d dbz=%b ovf=%b need q=%0d r=%0d dbz=%b ovf=%b",
                     name, q, r, div_by_zero, overflow, eq, er, edbz, eovf);
        end
    endtask

    task automatic test_basic();
        check_op("basic_13_3", 4'd13, 4'd3);
        tests++;
        if (q !== 4'd4 || r !== 4'd1) begin
            failures++;
            $display("FAIL basic_const: got q=%0d r=%0d need q=4 r=1", q, r);
        end
    endtask

    task automatic test_div_by_zero();
        check_op("dbz_7_0", 4'd7, 4'd0);
        tests++;
        if (q !== 4'd15 || r !== 4'd7 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_const: got q=%0d r=%0d dbz=%b need q=15 r=7 dbz=1", q, r, div_by_zero);
        end
    endtask

    task automatic test_boundaries();
        check_op("edge_15_1", 4'd15, 4'd1);
        check_op("edge_2_9", 4'd2, 4'd9);
        check_op("edge_14_9", 4'd14, 4'd9);
        check_op("edge_15_15", 4'd15, 4'd15);
        check_op("edge_0_5", 4'd0, 4'd5);
`ifdef NBIT_DIV_SIGNED_EN
        check_op("signed_m7_2", 4'b1001, 4'd2);
        tests++;
        if (q !== 4'b1101 || r !== 4'b1111) begin
            failures++;
            $display("FAIL signed_const: got q=%b r=%b need q=1101 r=1111", q, r);
        end
        check_op("signed_m8_m1", 4'b1000, 4'b1111);
        tests++;
        if (q !== 4'b1000 || r !== 4'b0000 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL signed_ovf: got q=%b r=%b ovf=%b need q=1000 r=0000 ovf=1", q, r, overflow);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            check_op("random", N'($urandom), N'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ax[3];
        logic [N-1:0] by[3];
        logic [N-1:0] eq, er;
        logic edbz, eovf;
        int c, dones, clash;
        for (int k = 0; k < 3; k++) begin
            ax[k] = N'($urandom);
            by[k] = N'($urandom_range(1, 2 ** N - 1));
        end
        c     = 0;
        dones = 0;
        clash = 0;
        start = 1'b1;
        while (c < 3 * (N + 2)) begin
            if (c % (N + 2) == 0) begin
                x = ax[c / (N + 2)];
                y = by[c / (N + 2)];
            end else begin
                x = N'($urandom);
                y = N'($urandom);
            end
            @(posedge clk); #1;
            c++;
            if (busy && done) clash++;
            if (done) begin
                tests++;
                if (dones >= 3 || c != dones * (N + 2) + N + 1) begin
                    failures++;
                    $display("FAIL b2b_timing: done #%0d at cycle %0d need cycle %0d",
                             dones, c, dones * (N + 2) + N + 1);
                end else begin
                    model(ax[dones], by[dones], eq, er, edbz, eovf);
                    if ({q, r, div_by_zero, overflow} !== {eq, er, edbz, eovf}) begin
                        failures++;
                        $display("FAIL b2b_result: op %0d x=%0d y=%0d got q=%0d r=%0d need q=%0d r=%0d",
                                 dones, ax[dones], by[dones], q, r, eq, er);
                    end
                end
                dones++;
            end
        end
        start = 1'b0;
        tests++;
        if (dones != 3 || clash != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses, %0d clashes; need 3 and 0", dones, clash);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start = 1'b1;
        x     = 4'd12;
        y     = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, q, r, div_by_zero, overflow} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b ovf=%b, need all 0",
                     busy, done, q, r, div_by_zero, overflow);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 2 * N + 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrun_abandon: got %0d active cycles after reset, need 0", seen);
        end
        check_op("after_reset_9_4", 4'd9, 4'd4);
        tests++;
        if (q !== 4'd2 || r !== 4'd1) begin
            failures++;
            $display("FAIL after_reset_const: got q=%0d r=%0d need q=2 r=1", q, r);
        end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
